mips_reg_file: RTL and testbench

//   Thirty-two-entry MIPS general-purpose register file for the single-cycle datapath.

---
 rtl/mips_reg_file.sv | 76 +++++++
 tb/tb_mips_reg_file.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mips_reg_file.sv
// rtl/mips_reg_file.sv - 32-entry MIPS register file with sequential clear sweep and write-first bypass
module mips_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    logic [0:0]        state;
    logic [ADDR_W:0]   clr_cnt;
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + CNT_ONE;
            if (clr_cnt == CNT_LAST) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end
        end
    end

    // Storage has no reset so it can map onto RAM; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                regs[clr_cnt[ADDR_W-1:0]] <= '0;
            end else if (we && (waddr != '0)) begin
                regs[waddr] <= wdata;
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        if (ready && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (ready && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_mips_reg_file.sv
// tb/tb_mips_reg_file.sv - self-checking bench for mips_reg_file (vectors, corner sequences, random vs model)
module tb_mips_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        ready;

    always #5 clk = ~clk;

    mips_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .ready  (ready)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: architectural contents plus edges elapsed since reset release.
    logic [31:0] m_regs [32];
    bit          m_ready = 1'b0;
    int          m_sweep = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!m_ready || a == 5'd0) return 32'd0;
        if (we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_ports(input string name);
        #1;
        check({name, ".rdata1"}, rdata1, exp_rd(raddr1));
        check({name, ".rdata2"}, rdata2, exp_rd(raddr2));
        check({name, ".ready"}, {31'd0, ready}, {31'd0, m_ready});
    endtask

    task automatic tick();
        if (reset) begin
            m_ready = 1'b0;
            m_sweep = 0;
        end else if (!m_ready) begin
            m_sweep++;
            if (m_sweep == 32) begin
                m_ready = 1'b1;
                foreach (m_regs[i]) m_regs[i] = 32'd0;
            end
        end else if (we && waddr != 5'd0) begin
            m_regs[waddr] = wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        idle();
    endtask

    // Releases reset and counts edges until ready, checking the 31-low/32nd-high timing.
    task automatic sweep_and_check(input string name);
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            check_ports(name);
            tick();
            if (k < 32) check({name, ".ready_low"}, {31'd0, ready}, 32'd0);
        end
        check({name, ".ready_at_32"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd9,  32'h0F0F0F0F, 5'd9,  5'd9,  32'h0F0F0F0F, 32'h0F0F0F0F};
        vecs[5] = '{1'b1, 5'd10, 32'h12345678, 5'd9,  5'd9,  32'h0F0F0F0F, 32'h0F0F0F0F};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd9,  32'h12345678, 32'h0F0F0F0F};
        vecs[7] = '{1'b1, 5'd9,  32'hCAFEF00D, 5'd9,  5'd8,  32'hCAFEF00D, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd31, 32'hCAFEF00D, 32'h0};
        vecs[9] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};

        // Reset state
        reset = 1'b1; idle(); raddr1 = 5'd7; raddr2 = 5'd12;
        tick();
        check_ports("reset");
        tick();
        check_ports("reset_hold");

        // Initial sweep with a write attempt to r5 throughout (must be ignored)
        we = 1'b1; waddr = 5'd5; wdata = 32'hAAAA5555; raddr2 = 5'd5;
        sweep_and_check("sweep_ignore_we");
        idle();
        raddr2 = 5'd5;
        check_ports("r5_after_sweep");
        check("r5_zero", rdata2, 32'd0);

        // Table-driven vectors from a freshly cleared file
        for (int i = 0; i < 10; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr1 = vecs[i].raddr1; raddr2 = vecs[i].raddr2;
            #1;
            check($sformatf("vec%0d.rdata1", i), rdata1, vecs[i].exp1);
            check($sformatf("vec%0d.rdata2", i), rdata2, vecs[i].exp2);
            tick();
        end
        idle();

        // Preload all ones, pulse reset once, verify sweep timing and cleared contents
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hFFFFFFFF);
        raddr1 = 5'd17; raddr2 = 5'd31;
        check_ports("preload");
        reset = 1'b1;
        tick();
        sweep_and_check("sweep_preload");
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            check($sformatf("clr%0d.rdata1", i), rdata1, 32'd0);
            check($sformatf("clr%0d.rdata2", i), rdata2, 32'd0);
        end

        // Reset on the 10th sweep edge restarts the sweep
        write_reg(5'd3, 32'h11);
        write_reg(5'd4, 32'h22);
        raddr1 = 5'd3; raddr2 = 5'd4;
        check_ports("r3r4_written");
        check("r3_val", rdata1, 32'h11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        check("midsweep.ready", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        tick();
        check_ports("midsweep_reset");
        sweep_and_check("sweep_restart");
        raddr1 = 5'd3; raddr2 = 5'd4;
        check_ports("r3r4_after");
        check("r3_zero", rdata1, 32'd0);
        check("r4_zero", rdata2, 32'd0);

        // Randomized traffic against the model, with occasional resets
        for (int n = 0; n < 600; n++) begin
            reset  = ($urandom_range(0, 199) == 0);
            we     = 1'($urandom_range(0, 1));
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            check_ports("random");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
